// File: rtl/dsp_config_loader_if.sv
// rtl/dsp_config_loader_if.sv - host-side configuration word stream (valid/ready)
interface dsp_config_loader_if #(
   parameter int WORD_W = 32
) ();
   logic [WORD_W-1:0] cfg_data;
   logic              cfg_valid;
   logic              cfg_ready;

   modport master (output cfg_data, output cfg_valid, input cfg_ready);
   modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/dsp_config_loader.sv
// rtl/dsp_config_loader.sv - serialises host configuration words LSB-first into the DSP slice scan chain
module dsp_config_loader #(
   parameter  int CHAIN_LEN = 256,
   parameter  int WORD_W    = 32,
   localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W,
   localparam int BCW       = $clog2(CHAIN_LEN + 1)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   dsp_config_loader_if.slave  cfg,
   output logic                configuration_input,
   output logic                configuration_enable,
   output logic                busy,
   output logic                done,
   output logic [BCW-1:0]      bit_count
);
   localparam int SBW = $clog2(WORD_W + 1);
   localparam int WAW = $clog2(NWORDS + 1);
   localparam logic [WAW-1:0] NWORDS_W = WAW'(NWORDS);
   localparam logic [BCW-1:0] LAST_BIT = BCW'(CHAIN_LEN - 1);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t            state;
   logic [WORD_W-1:0] shreg;
   logic [WORD_W-1:0] hold;
   logic [SBW-1:0]    shreg_bits;
   logic              hold_full;
   logic [WAW-1:0]    words_accepted;
   logic [BCW-1:0]    loaded_bits;

   logic              handshake;
   logic              shifting;
   logic              emptying;
   logic [31:0]       remaining;
   logic [SBW-1:0]    load_amt;

   assign cfg.cfg_ready = (state == S_SHIFT) && !hold_full && (words_accepted < NWORDS_W);
   assign handshake     = cfg.cfg_valid && cfg.cfg_ready;
   assign shifting      = (state == S_SHIFT) && (shreg_bits != '0);
   assign emptying      = (shreg_bits <= SBW'(1));

   // The final word only contributes the bits still owed to the chain.
   assign remaining = 32'(CHAIN_LEN) - 32'(loaded_bits);
   assign load_amt  = (remaining > 32'(WORD_W)) ? SBW'(WORD_W) : SBW'(remaining);

   assign configuration_input  = shreg[0];
   assign configuration_enable = shifting;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= S_IDLE;
         shreg          <= '0;
         hold           <= '0;
         shreg_bits     <= '0;
         hold_full      <= 1'b0;
         words_accepted <= '0;
         loaded_bits    <= '0;
         bit_count      <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state          <= S_SHIFT;
                  busy           <= 1'b1;
                  bit_count      <= '0;
                  words_accepted <= '0;
                  loaded_bits    <= '0;
                  shreg_bits     <= '0;
                  hold_full      <= 1'b0;
               end
            end
            S_SHIFT: begin
               if (shifting) begin
                  shreg      <= shreg >> 1;
                  shreg_bits <= shreg_bits - SBW'(1);
                  bit_count  <= bit_count + BCW'(1);
               end
               if (handshake) begin
                  words_accepted <= words_accepted + WAW'(1);
               end
               // Refill on the same edge the last bit leaves so a full stream stays gapless.
               if (emptying) begin
                  if (hold_full) begin
                     shreg       <= hold;
                     shreg_bits  <= load_amt;
                     loaded_bits <= loaded_bits + BCW'(load_amt);
                     hold_full   <= 1'b0;
                  end else if (handshake) begin
                     shreg       <= cfg.cfg_data;
                     shreg_bits  <= load_amt;
                     loaded_bits <= loaded_bits + BCW'(load_amt);
                  end
               end else if (handshake) begin
                  hold      <= cfg.cfg_data;
                  hold_full <= 1'b1;
               end
               if (shifting && (bit_count == LAST_BIT)) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               done  <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_dsp_config_loader.sv
// tb/tb_dsp_config_loader.sv - directed bench for the configuration chain loader
module tb_dsp_config_loader;
   logic       clk = 1'b0;
   logic       reset_n;
   logic       a_start, b_start;
   logic       a_in, a_en, a_busy, a_done;
   logic       b_in, b_en, b_busy, b_done;
   logic [5:0] a_bc, b_bc;

   always #5 clk = ~clk;

   dsp_config_loader_if #(.WORD_W(32)) a_if ();
   dsp_config_loader_if #(.WORD_W(32)) b_if ();

   dsp_config_loader #(.CHAIN_LEN(40), .WORD_W(32)) dut_a (
      .clk(clk), .reset_n(reset_n), .start(a_start), .cfg(a_if),
      .configuration_input(a_in), .configuration_enable(a_en),
      .busy(a_busy), .done(a_done), .bit_count(a_bc)
   );

   dsp_config_loader #(.CHAIN_LEN(32), .WORD_W(32)) dut_b (
      .clk(clk), .reset_n(reset_n), .start(b_start), .cfg(b_if),
      .configuration_input(b_in), .configuration_enable(b_en),
      .busy(b_busy), .done(b_done), .bit_count(b_bc)
   );

   int n_assert = 0;
   int n_fail   = 0;

   int          cyc = 0;
   int          a_nen, a_gap, a_hs, a_ndone, a_first, a_last, a_done_cyc;
   int          b_nen, b_hs, b_ndone;
   logic [63:0] a_stream, b_stream;

   // Observe the chain side: every enabled cycle is one bit pushed into the chain.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (a_en) begin
         if (a_nen < 64) a_stream[a_nen] = a_in;
         a_nen = a_nen + 1;
         if (a_first < 0) a_first = cyc;
         a_last = cyc;
      end
      if (a_busy && !a_en) a_gap = a_gap + 1;
      if (a_if.cfg_valid && a_if.cfg_ready) a_hs = a_hs + 1;
      if (a_done) begin
         a_ndone    = a_ndone + 1;
         a_done_cyc = cyc;
      end
      if (b_en) begin
         if (b_nen < 64) b_stream[b_nen] = b_in;
         b_nen = b_nen + 1;
      end
      if (b_if.cfg_valid && b_if.cfg_ready) b_hs = b_hs + 1;
      if (b_done) b_ndone = b_ndone + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      a_nen = 0; a_gap = 0; a_hs = 0; a_ndone = 0;
      a_first = -1; a_last = -1; a_done_cyc = -1; a_stream = '0;
      b_nen = 0; b_hs = 0; b_ndone = 0; b_stream = '0;
   endtask

   task automatic run_load(input logic [31:0] w0, input logic [31:0] w1, input int stall,
                           input bit keep_valid, input int restart_at, input int abort_at);
      int idx = 0;
      int low = 0;
      bit hs = 0;
      bit seen = 0;
      bit aborted = 0;
      @(posedge clk); #1;
      clear_mon();
      a_if.cfg_data  = w0;
      a_if.cfg_valid = 1'b1;
      a_start        = 1'b1;
      @(posedge clk); #1;
      a_start = 1'b0;
      for (int c = 0; c < 200 && !seen && !aborted; c++) begin
         @(negedge clk);
         hs = a_if.cfg_valid && a_if.cfg_ready;
         @(posedge clk); #1;
         if (hs) idx++;
         a_start = (c == restart_at);
         if (idx == 1) begin
            a_if.cfg_data = w1;
            if (!a_en) low++;
            a_if.cfg_valid = (low >= stall);
         end else if (idx >= 2) begin
            a_if.cfg_valid = keep_valid;
         end
         if (a_done) begin
            seen = 1;
            chk("busy_in_done", a_busy, 0);
            chk("bit_count_in_done", a_bc, 40);
         end
         if (abort_at > 0 && a_bc == 6'(abort_at)) begin
            reset_n = 1'b0;
            #1;
            chk("abort_enable", a_en, 0);
            chk("abort_ready", a_if.cfg_ready, 0);
            chk("abort_busy", a_busy, 0);
            chk("abort_bit_count", a_bc, 0);
            chk("abort_done", a_done, 0);
            chk("abort_bits_before_reset", a_nen, 17);
            aborted = 1;
         end
      end
      if (!aborted) chk("load_completes", seen, 1);
      a_start = 1'b0;
      if (!keep_valid) a_if.cfg_valid = 1'b0;
      @(posedge clk); #1;
      if (aborted) reset_n = 1'b1;
   endtask

   initial begin
      bit b_seen;
      bit hs;
      reset_n = 1'b0;
      a_start = 1'b0; b_start = 1'b0;
      a_if.cfg_valid = 1'b0; a_if.cfg_data = '0;
      b_if.cfg_valid = 1'b0; b_if.cfg_data = '0;
      clear_mon();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_enable", a_en, 0);
      chk("reset_ready", a_if.cfg_ready, 0);
      chk("reset_busy", a_busy, 0);
      chk("reset_done", a_done, 0);
      chk("reset_bit_count", a_bc, 0);
      chk("reset_serial", a_in, 0);
      chk("reset_b_busy", b_busy, 0);
      reset_n = 1'b1;

      run_load(32'hA5A5A5A5, 32'h000000C3, 0, 0, -1, 0);
      chk("gapless_stream", a_stream, 64'h00C3A5A5A5A5);
      chk("gapless_enable_count", a_nen, 40);
      chk("gapless_consecutive", a_last - a_first + 1, 40);
      chk("gapless_handshakes", a_hs, 2);
      chk("gapless_done_count", a_ndone, 1);
      chk("gapless_done_after_last", a_done_cyc, a_last + 1);
      chk("gapless_idle_busy_cycles", a_gap, 1);
      chk("gapless_idle_bit_count", a_bc, 40);

      run_load(32'hA5A5A5A5, 32'h000000C3, 5, 0, -1, 0);
      chk("stall_stream", a_stream, 64'h00C3A5A5A5A5);
      chk("stall_enable_count", a_nen, 40);
      chk("stall_handshakes", a_hs, 2);
      chk("stall_done_count", a_ndone, 1);
      chk("stall_low_cycles", a_gap, 6);

      run_load(32'hA5A5A5A5, 32'hFFFFFFFF, 0, 1, -1, 0);
      chk("trunc_stream", a_stream, 64'h00FFA5A5A5A5);
      chk("trunc_enable_count", a_nen, 40);
      chk("trunc_handshakes", a_hs, 2);
      repeat (4) @(posedge clk);
      #1;
      chk("idle_valid_ready", a_if.cfg_ready, 0);
      chk("idle_valid_no_handshake", a_hs, 2);
      chk("idle_valid_bit_count", a_bc, 40);
      a_if.cfg_valid = 1'b0;

      run_load(32'h12345678, 32'h0000009A, 0, 0, 10, 0);
      chk("restart_stream", a_stream, 64'h009A12345678);
      chk("restart_enable_count", a_nen, 40);
      chk("restart_done_count", a_ndone, 1);

      run_load(32'hA5A5A5A5, 32'h000000C3, 0, 0, -1, 17);
      chk("after_abort_bit_count", a_bc, 0);
      chk("after_abort_busy", a_busy, 0);
      run_load(32'h0F0F1234, 32'h00000055, 0, 0, -1, 0);
      chk("reload_stream", a_stream, 64'h00550F0F1234);
      chk("reload_enable_count", a_nen, 40);
      chk("reload_done_count", a_ndone, 1);

      @(posedge clk); #1;
      clear_mon();
      b_if.cfg_data  = 32'hDEADBEEF;
      b_if.cfg_valid = 1'b1;
      b_start        = 1'b1;
      @(posedge clk); #1;
      b_start = 1'b0;
      b_seen  = 0;
      for (int c = 0; c < 100 && !b_seen; c++) begin
         @(negedge clk);
         hs = b_if.cfg_valid && b_if.cfg_ready;
         @(posedge clk); #1;
         if (hs) b_if.cfg_valid = 1'b0;
         if (b_done) b_seen = 1;
      end
      chk("single_load_completes", b_seen, 1);
      @(posedge clk); #1;
      chk("single_handshakes", b_hs, 1);
      chk("single_enable_count", b_nen, 32);
      chk("single_stream", b_stream, 64'h00000000DEADBEEF);
      chk("single_done_count", b_ndone, 1);
      chk("single_bit_count", b_bc, 32);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
